// File: rtl/pe_pkg.sv
// Shared types, widths and the output narrowing helper for the SIMD MAC PE.
package pe_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int LANES      = 4;
    localparam int MULT_LAT   = 2;
    localparam int CNT_WIDTH  = 8;
    localparam int ACC_WIDTH  = 48;
    localparam int OUT_WIDTH  = 32;

    // Full-precision width of one beat: a signed product plus tree growth.
    localparam int PROD_WIDTH = 2*DATA_WIDTH + $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } pe_state_e;

    typedef struct packed {
        logic signed [OUT_WIDTH-1:0] value;
        logic                        ovf;
    } narrow_t;

    // Narrow an accumulator-width value to OUT_WIDTH. The value fits when every
    // bit from the output sign bit upward matches; otherwise clamp or wrap.
    function automatic narrow_t sat_narrow(input logic signed [ACC_WIDTH-1:0] value,
                                           input logic                        sat_en);
        narrow_t                       res;
        logic [ACC_WIDTH-OUT_WIDTH:0]  upper;
        logic                          fits;
        upper   = value[ACC_WIDTH-1:OUT_WIDTH-1];
        fits    = (&upper) | ~(|upper);
        res.ovf = ~fits;
        if (fits || !sat_en) begin
            res.value = value[OUT_WIDTH-1:0];
        end else if (value[ACC_WIDTH-1]) begin
            res.value = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            res.value = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_mac_simd_if.sv
// Job control, operand stream and psum result bundle of the SIMD MAC PE.
interface pe_mac_simd_if;
    import pe_pkg::*;

    logic                          start;
    logic                          clear;
    logic [CNT_WIDTH-1:0]          cfg_len;
    logic [5:0]                    cfg_shift;
    logic                          cfg_sat;
    logic signed [OUT_WIDTH-1:0]   psum_in;
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*DATA_WIDTH-1:0]   ifmap_data;
    logic [LANES*DATA_WIDTH-1:0]   fltr_data;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [OUT_WIDTH-1:0]   psum_out;
    logic                          busy;
    logic                          ovf;

    // Feeder / collector side.
    modport master (
        output start, clear, cfg_len, cfg_shift, cfg_sat, psum_in,
               in_valid, ifmap_data, fltr_data, out_ready,
        input  in_ready, out_valid, psum_out, busy, ovf
    );

    // PE side.
    modport slave (
        input  start, clear, cfg_len, cfg_shift, cfg_sat, psum_in,
               in_valid, ifmap_data, fltr_data, out_ready,
        output in_ready, out_valid, psum_out, busy, ovf
    );

endinterface

// File: rtl/pe_lane_mult_tree.sv
// LANES signed multipliers reduced to one full-precision sum, carried through
// MULT_LAT register stages with a valid bit; retiming spreads the tree.
module pe_lane_mult_tree
    import pe_pkg::*;
(
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush_i,
    input  logic                          in_vld_i,
    input  logic [LANES*DATA_WIDTH-1:0]   ifmap_i,
    input  logic [LANES*DATA_WIDTH-1:0]   fltr_i,
    output logic                          out_vld_o,
    output logic signed [PROD_WIDTH-1:0]  out_sum_o,
    output logic                          busy_o
);

    logic signed [2*DATA_WIDTH-1:0] prod [LANES];
    logic signed [PROD_WIDTH-1:0]   tree_sum;
    logic signed [PROD_WIDTH-1:0]   stg_q [MULT_LAT];
    logic                           vld_q [MULT_LAT];

    genvar gi;

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0] a_lane;
            logic signed [DATA_WIDTH-1:0] b_lane;
            assign a_lane   = ifmap_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign b_lane   = fltr_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign prod[gi] = a_lane * b_lane;
        end
    endgenerate

    // Sign-extend each lane product and reduce across lanes.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + PROD_WIDTH'(prod[i]);
        end
    end

    generate
        for (gi = 0; gi < MULT_LAT; gi++) begin : g_stage
            // One pipeline stage; flush drops valids but leaves data as-is.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    vld_q[gi] <= 1'b0;
                    stg_q[gi] <= '0;
                end else if (flush_i) begin
                    vld_q[gi] <= 1'b0;
                end else begin
                    if (gi == 0) begin
                        vld_q[gi] <= in_vld_i;
                        stg_q[gi] <= tree_sum;
                    end else begin
                        vld_q[gi] <= vld_q[(gi == 0) ? 0 : gi-1];
                        stg_q[gi] <= stg_q[(gi == 0) ? 0 : gi-1];
                    end
                end
            end
        end
    endgenerate

    // Any beat still in flight keeps the PE from leaving DRAIN.
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < MULT_LAT; i++) begin
            busy_o = busy_o | vld_q[i];
        end
    end

    assign out_vld_o = vld_q[MULT_LAT-1];
    assign out_sum_o = stg_q[MULT_LAT-1];

endmodule

// File: rtl/pe_mac_simd.sv
// SIMD convolution PE: job FSM, beat counter, wide accumulator and a two-step
// output stage (arithmetic shift, then saturate/wrap narrowing).
module pe_mac_simd
    import pe_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    pe_mac_simd_if.slave  bus
);

    generate
        if (ACC_WIDTH < 2*DATA_WIDTH + $clog2(LANES) + CNT_WIDTH + 1) begin : g_acc_check
            $error("ACC_WIDTH too narrow for a full-length job");
        end
        if (LANES < 1 || MULT_LAT < 1) begin : g_param_check
            $error("LANES and MULT_LAT must be at least 1");
        end
    endgenerate

    pe_state_e                    state_q, state_d;
    logic [CNT_WIDTH-1:0]         rem_q;
    logic [5:0]                   shift_q;
    logic                         sat_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  shifted_q;
    logic                         acc_vld_q;
    logic signed [OUT_WIDTH-1:0]  psum_q;
    logic                         ovf_q;

    logic                         start_ok, beat, drain_done;
    logic                         pipe_vld, pipe_busy;
    logic signed [PROD_WIDTH-1:0] pipe_sum;
    logic signed [ACC_WIDTH-1:0]  seed_ext, seed_shifted, pipe_ext;
    narrow_t                      seed_nar, drain_nar;

    pe_lane_mult_tree u_tree (
        .clk       (clk),
        .rstn      (rstn),
        .flush_i   (bus.clear),
        .in_vld_i  (beat),
        .ifmap_i   (bus.ifmap_data),
        .fltr_i    (bus.fltr_data),
        .out_vld_o (pipe_vld),
        .out_sum_o (pipe_sum),
        .busy_o    (pipe_busy)
    );

    assign start_ok     = (state_q == IDLE) && bus.start && !bus.clear;
    assign beat         = (state_q == ACCUM) && bus.in_valid && !bus.clear;
    // The last product has been added and the shift stage has seen it.
    assign drain_done   = (state_q == DRAIN) && !pipe_busy && !acc_vld_q;

    assign seed_ext     = {{(ACC_WIDTH-OUT_WIDTH){bus.psum_in[OUT_WIDTH-1]}}, bus.psum_in};
    assign seed_shifted = seed_ext >>> bus.cfg_shift;
    assign pipe_ext     = {{(ACC_WIDTH-PROD_WIDTH){pipe_sum[PROD_WIDTH-1]}}, pipe_sum};
    assign seed_nar     = sat_narrow(seed_shifted, bus.cfg_sat);
    assign drain_nar    = sat_narrow(shifted_q, sat_q);

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == OUT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.psum_out  = psum_q;
    assign bus.ovf       = ovf_q;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (bus.cfg_len == '0) ? OUT : ACCUM;
            ACCUM:   if (beat && rem_q == CNT_WIDTH'(1)) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = OUT;
            OUT:     if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.clear) begin
            state_d = IDLE;
        end
    end

    // Job configuration, beat counter, accumulator and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem_q     <= '0;
            shift_q   <= '0;
            sat_q     <= 1'b0;
            acc_q     <= '0;
            shifted_q <= '0;
            acc_vld_q <= 1'b0;
            psum_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            acc_vld_q <= pipe_vld && !bus.clear;
            shifted_q <= acc_q >>> shift_q;
            if (!bus.clear) begin
                if (start_ok) begin
                    shift_q <= bus.cfg_shift;
                    sat_q   <= bus.cfg_sat;
                    rem_q   <= bus.cfg_len;
                    acc_q   <= seed_ext;
                    ovf_q   <= 1'b0;
                    if (bus.cfg_len == '0) begin
                        psum_q <= seed_nar.value;
                        ovf_q  <= seed_nar.ovf;
                    end
                end else if (pipe_vld) begin
                    acc_q <= acc_q + pipe_ext;
                end
                if (beat) begin
                    rem_q <= rem_q - CNT_WIDTH'(1);
                end
                if (drain_done) begin
                    psum_q <= drain_nar.value;
                    ovf_q  <= ovf_q | drain_nar.ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_simd.sv
// Self-checking bench for pe_mac_simd: job-level reference model plus a
// per-cycle output comparator, directed cases and randomized jobs.
`timescale 1ns/1ps
module tb_pe_mac_simd;
    import pe_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pe_mac_simd_if bus();

    pe_mac_simd dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        longint val;
        bit     ovf;
    } exp_t;

    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc   = 0;
    exp_t   exp_q[$];
    longint last_psum = 0;
    longint last_ovf  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Job result from plain arithmetic: exact sum, shift, then clamp or wrap.
    function automatic exp_t model(input longint exact, input int shift, input bit sat);
        exp_t   r;
        longint s;
        longint lo = -64'sd2147483648;
        longint hi = 64'sd2147483647;
        s     = exact >>> shift;
        r.ovf = (s < lo) || (s > hi);
        if (!r.ovf)     r.val = s;
        else if (sat)   r.val = (s < 0) ? lo : hi;
        else            r.val = longint'(int'(s));
        return r;
    endfunction

    // Whenever a result is presented, it must match the oldest expected job.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("psum_out", longint'(bus.psum_out), exp_q[0].val);
                    chk("ovf", longint'(bus.ovf), longint'(exp_q[0].ovf));
                    if (bus.out_ready) begin
                        last_psum = longint'(bus.psum_out);
                        last_ovf  = longint'(bus.ovf);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // dmode: 0 const 2*3, 1 all -32768, 2 random, 3 lane0 1*5 others 0, 4 extremes
    // bmode: 0 no bubbles, 1 alternate 1,0,1..., 2 random bubbles
    task automatic run_job(input string tag, input int len, input int psum, input int shift,
                           input bit sat, input int dmode, input int bmode, input int stall,
                           input int abort_at, input bit rst_drain, input bit start_in_out);
        longint exact = longint'(psum);
        longint bsum;
        int     cnt = 0, k = 0, s0, c0 = 0, c1, guard = 0;
        bit     v, rdy, seen;
        logic [LANES*DATA_WIDTH-1:0] fm, ft;
        exp_t   e;

        while (bus.busy && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        bus.start     = 1'b1;
        bus.cfg_len   = CNT_WIDTH'(len);
        bus.cfg_shift = 6'(shift);
        bus.cfg_sat   = sat;
        bus.psum_in   = psum;
        @(negedge clk); s0 = cyc;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.cfg_shift = 6'($urandom);
        bus.cfg_sat   = 1'($urandom);
        bus.psum_in   = $urandom;
        bus.cfg_len   = CNT_WIDTH'($urandom);
        if (len > 0) begin
            @(negedge clk);
            chk({tag, "_ovf_cleared"}, longint'(bus.ovf), 0);
            chk({tag, "_busy"}, longint'(bus.busy), 1);
            @(posedge clk); #1;
        end

        while (cnt < len && k < 4000) begin
            bsum = 0;
            for (int i = 0; i < LANES; i++) begin
                logic signed [DATA_WIDTH-1:0] a, b;
                case (dmode)
                    0:       begin a = 2; b = 3; end
                    1:       begin a = -16'sd32768; b = -16'sd32768; end
                    3:       begin a = (i == 0) ? 16'sd1 : 16'($urandom); b = (i == 0) ? 16'sd5 : 16'sd0; end
                    4:       begin a = $urandom_range(0, 1) ? -16'sd32768 : 16'sd32767;
                                   b = $urandom_range(0, 1) ? -16'sd32768 : 16'sd32767; end
                    default: begin a = 16'($urandom); b = 16'($urandom); end
                endcase
                fm[i*DATA_WIDTH +: DATA_WIDTH] = a;
                ft[i*DATA_WIDTH +: DATA_WIDTH] = b;
                bsum += longint'(a) * longint'(b);
            end
            if (abort_at >= 0 && cnt == abort_at) begin
                bus.in_valid = 1'b1; bus.ifmap_data = fm; bus.fltr_data = ft;
                bus.clear = 1'b1;
                @(posedge clk); #1;
                bus.clear = 1'b0; bus.in_valid = 1'b0;
                @(negedge clk);
                chk({tag, "_busy_after_clear"}, longint'(bus.busy), 0);
                chk({tag, "_out_valid_after_clear"}, longint'(bus.out_valid), 0);
                @(posedge clk); #1;
                return;
            end
            v = (bmode == 0) ? 1'b1 : (bmode == 1) ? (k % 2 == 0) : ($urandom_range(0, 3) != 0);
            bus.in_valid = v; bus.ifmap_data = fm; bus.fltr_data = ft;
            @(negedge clk);
            rdy = bus.in_ready;
            chk({tag, "_in_ready_accum"}, longint'(rdy), 1);
            if (v && rdy) begin
                exact += bsum; cnt++; c0 = cyc + 1;
            end
            @(posedge clk); #1;
            k++;
        end
        bus.in_valid = 1'b0;
        if (cnt < len) chk({tag, "_beat_timeout"}, cnt, len);

        if (rst_drain) begin
            #2 rstn = 1'b0;
            #1;
            chk({tag, "_rst_in_ready"}, longint'(bus.in_ready), 0);
            chk({tag, "_rst_out_valid"}, longint'(bus.out_valid), 0);
            chk({tag, "_rst_psum_out"}, longint'(bus.psum_out), 0);
            chk({tag, "_rst_busy"}, longint'(bus.busy), 0);
            chk({tag, "_rst_ovf"}, longint'(bus.ovf), 0);
            @(posedge clk); #3 rstn = 1'b1;
            @(posedge clk); #1;
            return;
        end

        e = model(exact, shift, sat);
        exp_q.push_back(e);

        seen = 1'b0; guard = 0;
        while (!seen && guard < 50) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            else begin
                if (len > 0) chk({tag, "_in_ready_drain"}, longint'(bus.in_ready), 0);
                guard++;
            end
        end
        if (!seen) begin
            chk({tag, "_out_valid_timeout"}, 0, 1);
            exp_q.delete();
            @(posedge clk); #1 bus.clear = 1'b1;
            @(posedge clk); #1 bus.clear = 1'b0;
            return;
        end
        c1 = cyc;
        if (len > 0) chk({tag, "_latency"}, c1 - c0, MULT_LAT + 2);
        else         chk({tag, "_latency"}, c1 - s0, 1);

        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (start_in_out && s == 1) begin
                bus.start = 1'b1; bus.cfg_len = '0; bus.psum_in = 1234;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            chk({tag, "_stall_out_valid"}, longint'(bus.out_valid), 1);
            chk({tag, "_stall_in_ready"}, longint'(bus.in_ready), 0);
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_busy"}, longint'(bus.busy), 0);
        chk({tag, "_idle_out_valid"}, longint'(bus.out_valid), 0);
        chk({tag, "_consumed"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 0; bus.clear = 0; bus.cfg_len = '0; bus.cfg_shift = '0; bus.cfg_sat = 0;
        bus.psum_in = '0; bus.in_valid = 0; bus.ifmap_data = '0; bus.fltr_data = '0;
        bus.out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", longint'(bus.in_ready), 0);
        chk("reset_out_valid", longint'(bus.out_valid), 0);
        chk("reset_psum_out", longint'(bus.psum_out), 0);
        chk("reset_busy", longint'(bus.busy), 0);
        chk("reset_ovf", longint'(bus.ovf), 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        run_job("basic", 3, 10, 0, 0, 0, 0, 0, -1, 0, 0);
        chk("basic_literal", last_psum, 82);
        chk("basic_literal_ovf", last_ovf, 0);

        run_job("bubble", 3, 10, 0, 0, 0, 1, 5, -1, 0, 0);
        chk("bubble_literal", last_psum, 82);

        run_job("sat", 255, 0, 0, 1, 1, 0, 1, -1, 0, 0);
        chk("sat_literal", last_psum, 64'sd2147483647);
        chk("sat_literal_ovf", last_ovf, 1);

        run_job("wrap", 255, 0, 0, 0, 1, 0, 1, -1, 0, 0);
        chk("wrap_literal", last_psum, 0);
        chk("wrap_literal_ovf", last_ovf, 1);
        chk("ovf_sticky_idle", longint'(bus.ovf), 1);

        run_job("after_ovf", 2, 0, 0, 0, 2, 0, 0, -1, 0, 0);

        run_job("shift", 0, -7, 1, 0, 0, 0, 4, -1, 0, 1);
        chk("shift_literal", last_psum, -4);

        run_job("abort", 5, 0, 0, 0, 2, 0, 0, 2, 0, 0);
        run_job("post_abort", 1, 0, 0, 0, 3, 0, 0, -1, 0, 0);
        chk("post_abort_literal", last_psum, 5);

        run_job("rst", 3, 10, 0, 0, 0, 0, 0, -1, 1, 0);
        run_job("post_rst", 3, 10, 0, 0, 0, 0, 0, -1, 0, 0);
        chk("post_rst_literal", last_psum, 82);

        for (int j = 0; j < 25; j++) begin
            int sh;
            sh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 8);
            run_job("rand", $urandom_range(0, 12), $urandom, sh, 1'($urandom),
                    $urandom_range(0, 1) ? 2 : 4, $urandom_range(0, 1) ? 2 : 0,
                    $urandom_range(0, 3), -1, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pe_mac_simd.md
Name: pe_mac_simd

Overview:
- Next-generation convolution PE: LANES signed ifmap×filter products per beat, reduced by an adder tree, accumulated over a programmable number of beats.
- Output is a shifted, optionally saturated partial sum, delivered on a valid/ready handshake.
- Sits inside the PE array between the ifmap/filter feeders and the psum collection network.
- Replaces the fixed single-lane PE with its bare combinational psum path.

Parameters:
- DATA_WIDTH, 16: signed width of each ifmap/filter element.
- LANES, 4: multipliers per beat (≥1).
- MULT_LAT, 2: pipeline stages in the multiply + adder-tree path (≥1).
- CNT_WIDTH, 8: width of the beat-count field.
- ACC_WIDTH, 48: internal accumulator width. Elaboration check: ≥ 2*DATA_WIDTH + $clog2(LANES) + CNT_WIDTH + 1.
- OUT_WIDTH, 32: signed width of psum_in / psum_out.

Ports:
- clk, in, 1: clock.
- rstn, in, 1: asynchronous active-low reset.
- start, in, 1: begin job; sampled only in IDLE.
- clear, in, 1: synchronous abort to IDLE.
- cfg_len, in, CNT_WIDTH: beats to accumulate; sampled with start.
- cfg_shift, in, 6: arithmetic right shift applied at output; sampled with start.
- cfg_sat, in, 1: 1 = saturate, 0 = wrap; sampled with start.
- psum_in, in, OUT_WIDTH: signed accumulator seed; sampled with start.
- in_valid, in, 1: operand beat valid.
- in_ready, out, 1: PE accepts a beat.
- ifmap_data, in, LANES*DATA_WIDTH: packed signed lanes, lane 0 in the LSBs.
- fltr_data, in, LANES*DATA_WIDTH: packed signed lanes, lane 0 in the LSBs.
- out_valid, out, 1: psum_out valid.
- out_ready, in, 1: downstream accepts.
- psum_out, out, OUT_WIDTH: result.
- busy, out, 1: state != IDLE.
- ovf, out, 1: sticky; set when the output was clamped or wrapped; cleared on an accepted start.

Behaviour:
- Reset: state IDLE; in_ready=0, out_valid=0, psum_out=0, busy=0, ovf=0; accumulator, counter and pipeline valid bits cleared.
- FSM states: IDLE, ACCUM, DRAIN, OUT.
- IDLE:
  - start=1 latches cfg_* and psum_in; the accumulator takes the sign-extended psum_in.
  - cfg_len≠0 → ACCUM.
  - cfg_len=0 → OUT directly; the output is psum_in shifted/saturated.
- ACCUM:
  - in_ready=1. A beat transfers on in_valid&in_ready; in_valid=0 is a bubble and is not counted.
  - Each transferred beat enters the MULT_LAT-deep pipeline as sum over lanes of signed(ifmap[i])*signed(fltr[i]), full precision, sign-extended to ACC_WIDTH.
  - The pipeline output is added to the accumulator on the following edge.
  - When the cfg_len-th beat transfers → DRAIN; in_ready drops in the same cycle.
- DRAIN:
  - in_ready=0. Waits until the pipeline valid bits are all zero and the last product is accumulated, then → OUT.
- OUT:
  - Registered psum_out = f(acc >>> cfg_shift):
    - cfg_sat=1: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
    - cfg_sat=0: truncate to the low OUT_WIDTH bits.
  - ovf is set if the shifted value does not fit in OUT_WIDTH.
  - out_valid=1; psum_out and out_valid stay stable until out_ready=1, then → IDLE.
- Latency: out_valid asserts MULT_LAT+2 cycles after the edge that transferred the last beat. cfg_len=0 gives 1 cycle after start.
- Throughput: one beat per cycle in ACCUM; zero-bubble accumulation.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored (in_ready=0).
- clear (any state): → IDLE next edge; pipeline flushed, out_valid=0, ovf retained. clear has priority over start and over handshakes in the same cycle.
- Reset mid-operation: all state lost, same values as reset. No partial result is emitted.
- The accumulator never overflows internally, guaranteed by the parameter check. Overflow is possible only at output narrowing.

Decomposition:
- Package pe_pkg:
  - pe_state_e enum (IDLE, ACCUM, DRAIN, OUT).
  - localparam PROD_WIDTH = 2*DATA_WIDTH + $clog2(LANES).
  - Function sat_narrow(value, sat_en) returning the narrowed value and an overflow flag.
- Sub-module pe_lane_mult_tree: LANES signed multipliers plus a pipelined adder tree, MULT_LAT stages, with a valid bit carried alongside the data. The top level holds the FSM, counter, accumulator and output stage.

Test Plan:
- LANES=4, cfg_len=3, psum_in=10, shift=0, sat=0, all lanes ifmap=2 and fltr=3 every beat, no bubbles → psum_out=10+3*24=82, ovf=0, out_valid exactly MULT_LAT+2 cycles after the 3rd beat.
- Same job with in_valid toggled 1,0,1,0,1 and out_ready held low 5 cycles → result 82, exactly 3 beats counted, psum_out stable while stalled, in_ready=0 during DRAIN/OUT.
- Overflow case: ifmap=fltr=-32768 on all lanes, cfg_len=255, OUT_WIDTH=32.
  - sat=1 → psum_out=0x7FFFFFFF, ovf=1.
  - Repeat with sat=0 → psum_out equals the low 32 bits of the exact sum, ovf=1.
  - Next start clears ovf.
- Shift and sign handling: cfg_len=0, psum_in=-7, shift=1 → psum_out=-4 one cycle after start; start pulsed during OUT is ignored.
- Abort: clear asserted mid-ACCUM after 2 of 5 beats, then a new job with cfg_len=1 and products summing to 5, psum_in=0 → psum_out=5, with no contribution from the aborted beats.
- Reset: rstn pulsed low asynchronously (between clock edges) during DRAIN → all outputs 0 immediately, state IDLE, next job correct.
